instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the CPU control unit.
- Owns the program counter and issues instruction reads on the shared bus while the control unit is in FETCH.
- Captures the returned word into an instruction register and decodes it to the numeric instruction ID the control unit consumes (loads/stores = 27..34).
- Advances the PC when the control unit pulses load_PC, using either PC+4 or a redirect target.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before a fetch is abandoned and reissued (1..255).

Ports:
- i_clk  in  1  system clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_state  in  1  control unit state: 0 = FETCH, 1 = EXECUTE
- i_load_PC  in  1  one-cycle pulse from the control unit: instruction retired, advance PC
- i_branch_taken  in  1  sampled with i_load_PC: 1 = redirect to i_branch_target
- i_branch_target  in  32  redirect address
- i_bus_DV  in  1  bus data valid
- i_bus_data  in  32  bus read data
- o_bus_read  out  1  one-cycle read request
- o_bus_addr  out  32  read address, equal to o_pc
- o_pc  out  32  current PC
- o_instruction_word  out  32  instruction register
- o_instruction  out  6  decoded instruction ID (zero-extended by the consumer)
- o_misaligned  out  1  one-cycle pulse: redirect target had bits[1:0] != 0
- o_bus_timeout  out  1  sticky: at least one fetch timed out

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - PC=RESET_VECTOR; IR=32'h0000_0013.
  - o_instruction=10 (ADDI, i.e. NOP).
  - o_bus_read=0, o_misaligned=0, o_bus_timeout=0.
  - State IDLE; timeout counter=0.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - If i_state=0, go to REQ.
  - i_bus_DV is ignored, including late data after a reset.
- REQ:
  - o_bus_read=1 for exactly this cycle, o_bus_addr=PC.
  - Counter cleared; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On i_bus_DV: IR<=i_bus_data, o_instruction<=decode(i_bus_data), go to HOLD.
  - Latency is REQ, then WAIT, then capture on the first DV cycle; IR/ID are valid the cycle after DV.
  - DV arrives in the same cycle the control unit leaves FETCH; both sample the same edge.
  - If the counter reaches TIMEOUT_CYCLES without DV: set o_bus_timeout, go to REQ (reissue at the same PC).
  - DV in the timeout cycle wins: data is captured, no timeout is flagged.
- HOLD:
  - IR/ID are stable. i_bus_DV is ignored, since load/store data returns here.
  - On i_load_PC:
    - If i_branch_taken: PC<={i_branch_target[31:2],2'b00}, and o_misaligned pulses if target[1:0]!=0.
    - Otherwise: PC<=PC+4, wrapping modulo 2^32 (32'hFFFF_FFFC → 0).
    - Go to IDLE.
- i_load_PC outside HOLD is ignored (no PC change).
- The earliest new REQ is 2 cycles after i_load_PC (IDLE, then REQ), provided i_state=0.
- Decode IDs (RV32I, opcode/funct3/funct7):
  - LUI0 AUIPC1 JAL2 JALR3
  - BEQ4 BNE5 BLT6 BGE7 BLTU8 BGEU9
  - ADDI10 SLTI11 SLTIU12 XORI13 ORI14 ANDI15 SLLI16 SRLI17 SRAI18
  - ADD19 SUB20 SLL21 SLT22 SLTU23 XOR24 SRL25 SRA26
  - LB27 LH28 LW29 LBU30 LHU31 SB32 SH33 SW34
  - FENCE35 ECALL36 EBREAK37
  - Any other encoding = 63 (illegal).
  - funct7 is checked for shifts and R-type; a bad funct7 → 63.

Test Plan:
- Reset then i_state=0, bus returns 32'h0000_0013 after 3 cycles → single o_bus_read with addr 0; IR=32'h13; ID=10; PC stays 0 until i_load_PC.
- Hold in HOLD, pulse i_load_PC with taken=0 → PC=4, next read addr=4. Then taken=1 with target 32'h0000_0102 → PC=32'h100 and o_misaligned pulses once.
- Fetch 32'h0000_2083 (LW) → ID=29. During the following EXECUTE, an extra DV with data 32'hDEAD_BEEF → IR unchanged.
- No DV for TIMEOUT_CYCLES (set to 4) → o_bus_timeout=1, second o_bus_read at the same address. DV then captures normally.
- Deassert i_rst_n while in WAIT, DV arrives 1 cycle after release → ignored; PC=RESET_VECTOR; all outputs at reset values.
- PC=32'hFFFF_FFFC, i_load_PC with taken=0 → PC=0. Fetch 32'h4000_0033 (SUB) → ID=20; 32'h0200_0033 → ID=63.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues instruction reads on the shared bus while the
// control unit is in FETCH, and latches/decodes the returned word for the control unit.
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_state,
  input  logic        i_load_PC,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_bus_DV,
  input  logic [31:0] i_bus_data,
  output logic        o_bus_read,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction_word,
  output logic [5:0]  o_instruction,
  output logic        o_misaligned,
  output logic        o_bus_timeout
);

  localparam logic [31:0] NOP_WORD      = 32'h0000_0013;
  localparam logic [5:0]  NOP_ID        = 6'd10;
  localparam logic [5:0]  ID_ILLEGAL    = 6'd63;
  localparam logic [7:0]  TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t      state_r, state_next_s;
  logic [7:0]  wait_cnt_r, wait_cnt_next_s, wait_cnt_inc_s;
  logic [31:0] pc_r, pc_next_s;
  logic [31:0] ir_r, ir_next_s;
  logic [5:0]  id_r, id_next_s;
  logic        bus_read_r;
  logic        misaligned_r, misaligned_next_s;
  logic        timeout_r, timeout_next_s;

  // RV32I word to the numeric instruction ID; anything unlisted is illegal.
  function automatic logic [5:0] decode(input logic [31:0] word);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [5:0] id;
    opcode = word[6:0];
    funct3 = word[14:12];
    funct7 = word[31:25];
    id     = ID_ILLEGAL;
    case (opcode)
      OP_LUI:   id = 6'd0;
      OP_AUIPC: id = 6'd1;
      OP_JAL:   id = 6'd2;
      OP_JALR: begin
        if (funct3 == 3'b000) id = 6'd3;
        else                  id = ID_ILLEGAL;
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  id = 6'd4;
          3'b001:  id = 6'd5;
          3'b100:  id = 6'd6;
          3'b101:  id = 6'd7;
          3'b110:  id = 6'd8;
          3'b111:  id = 6'd9;
          default: id = ID_ILLEGAL;
        endcase
      end
      OP_IMM: begin
        case (funct3)
          3'b000: id = 6'd10;
          3'b010: id = 6'd11;
          3'b011: id = 6'd12;
          3'b100: id = 6'd13;
          3'b110: id = 6'd14;
          3'b111: id = 6'd15;
          3'b001: begin
            if (funct7 == 7'b0000000) id = 6'd16;
            else                      id = ID_ILLEGAL;
          end
          3'b101: begin
            if (funct7 == 7'b0000000)      id = 6'd17;
            else if (funct7 == 7'b0100000) id = 6'd18;
            else                           id = ID_ILLEGAL;
          end
          default: id = ID_ILLEGAL;
        endcase
      end
      // OR/AND have no ID in the control unit's table, so they decode as illegal.
      OP_REG: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  id = 6'd19;
            3'b001:  id = 6'd21;
            3'b010:  id = 6'd22;
            3'b011:  id = 6'd23;
            3'b100:  id = 6'd24;
            3'b101:  id = 6'd25;
            default: id = ID_ILLEGAL;
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000:  id = 6'd20;
            3'b101:  id = 6'd26;
            default: id = ID_ILLEGAL;
          endcase
        end else begin
          id = ID_ILLEGAL;
        end
      end
      OP_LOAD: begin
        case (funct3)
          3'b000:  id = 6'd27;
          3'b001:  id = 6'd28;
          3'b010:  id = 6'd29;
          3'b100:  id = 6'd30;
          3'b101:  id = 6'd31;
          default: id = ID_ILLEGAL;
        endcase
      end
      OP_STORE: begin
        case (funct3)
          3'b000:  id = 6'd32;
          3'b001:  id = 6'd33;
          3'b010:  id = 6'd34;
          default: id = ID_ILLEGAL;
        endcase
      end
      OP_FENCE: begin
        if (funct3 == 3'b000) id = 6'd35;
        else                  id = ID_ILLEGAL;
      end
      OP_SYSTEM: begin
        if (word == 32'h0000_0073)      id = 6'd36;
        else if (word == 32'h0010_0073) id = 6'd37;
        else                            id = ID_ILLEGAL;
      end
      default: id = ID_ILLEGAL;
    endcase
    return id;
  endfunction

  // Next-state, PC update, capture and flag logic for the fetch FSM.
  always_comb begin
    state_next_s      = state_r;
    wait_cnt_next_s   = wait_cnt_r;
    pc_next_s         = pc_r;
    ir_next_s         = ir_r;
    id_next_s         = id_r;
    misaligned_next_s = 1'b0;
    timeout_next_s    = timeout_r;
    wait_cnt_inc_s    = wait_cnt_r + 8'd1;
    case (state_r)
      ST_IDLE: begin
        if (i_state == 1'b0) state_next_s = ST_REQ;
        else                 state_next_s = ST_IDLE;
      end
      ST_REQ: begin
        wait_cnt_next_s = 8'd0;
        state_next_s    = ST_WAIT;
      end
      // Data valid in the final counted cycle still wins over the timeout.
      ST_WAIT: begin
        wait_cnt_next_s = wait_cnt_inc_s;
        if (i_bus_DV) begin
          ir_next_s    = i_bus_data;
          id_next_s    = decode(i_bus_data);
          state_next_s = ST_HOLD;
        end else if (wait_cnt_inc_s >= TIMEOUT_LIMIT) begin
          timeout_next_s = 1'b1;
          state_next_s   = ST_REQ;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (i_load_PC) begin
          if (i_branch_taken) begin
            pc_next_s         = {i_branch_target[31:2], 2'b00};
            misaligned_next_s = (i_branch_target[1:0] != 2'b00);
          end else begin
            pc_next_s = pc_r + 32'd4;
          end
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State and output registers; the read strobe is registered from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= ST_IDLE;
      wait_cnt_r   <= 8'd0;
      pc_r         <= RESET_VECTOR;
      ir_r         <= NOP_WORD;
      id_r         <= NOP_ID;
      bus_read_r   <= 1'b0;
      misaligned_r <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      wait_cnt_r   <= wait_cnt_next_s;
      pc_r         <= pc_next_s;
      ir_r         <= ir_next_s;
      id_r         <= id_next_s;
      bus_read_r   <= (state_next_s == ST_REQ);
      misaligned_r <= misaligned_next_s;
      timeout_r    <= timeout_next_s;
    end
  end

  assign o_bus_read         = bus_read_r;
  assign o_bus_addr         = pc_r;
  assign o_pc               = pc_r;
  assign o_instruction_word = ir_r;
  assign o_instruction      = id_r;
  assign o_misaligned       = misaligned_r;
  assign o_bus_timeout      = timeout_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed sequences, a decode vector table,
// and randomized fetch/retire traffic checked against a mask/match reference model.
module tb_instruction_fetch;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_state;
  logic        load_pc;
  logic        taken;
  logic [31:0] target;
  logic        dv;
  logic [31:0] bdata;
  logic        o_bus_read;
  logic [31:0] o_bus_addr;
  logic [31:0] o_pc;
  logic [31:0] o_instruction_word;
  logic [5:0]  o_instruction;
  logic        o_misaligned;
  logic        o_bus_timeout;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_VECTOR  (32'h0000_0000),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_state           (i_state),
    .i_load_PC         (load_pc),
    .i_branch_taken    (taken),
    .i_branch_target   (target),
    .i_bus_DV          (dv),
    .i_bus_data        (bdata),
    .o_bus_read        (o_bus_read),
    .o_bus_addr        (o_bus_addr),
    .o_pc              (o_pc),
    .o_instruction_word(o_instruction_word),
    .o_instruction     (o_instruction),
    .o_misaligned      (o_misaligned),
    .o_bus_timeout     (o_bus_timeout)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_ir;
  logic [5:0]  exp_id;
  logic        exp_to;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [5:0]  id;
  } pat_t;
  pat_t pats[$];

  typedef struct {
    logic [31:0] word;
    logic [5:0]  id;
    int          delay;
    logic        tk;
    logic [31:0] tgt;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [5:0] ref_decode(input logic [31:0] w);
    foreach (pats[i]) begin
      if ((w & pats[i].mask) == pats[i].match) return pats[i].id;
    end
    return 6'd63;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic wait_read(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (o_bus_read === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    chk("read_issued", 32'(seen), 32'd1);
  endtask

  // d = number of empty WAIT cycles before data valid; d >= TO forces timeouts.
  task automatic fetch(input logic [31:0] word, input logic [5:0] eid, input int d);
    bit seen;
    bit done;
    int rem;
    wait_read(seen);
    if (seen) begin
      chk("bus_addr", o_bus_addr, exp_pc);
      rem  = d;
      done = 1'b0;
      while (!done) begin
        for (int k = 0; k < TO && !done; k++) begin
          @(negedge clk);
          chk("read_one_cycle", 32'(o_bus_read), 32'd0);
          if (k == rem) begin
            dv      = 1'b1;
            bdata   = word;
            i_state = 1'b1;
            done    = 1'b1;
          end
        end
        if (!done) begin
          exp_to = 1'b1;
          rem    = rem - TO;
          @(negedge clk);
          chk("reissue_read", 32'(o_bus_read), 32'd1);
          chk("reissue_addr", o_bus_addr, exp_pc);
          chk("timeout_flag", 32'(o_bus_timeout), 32'd1);
        end
      end
      @(negedge clk);
      dv     = 1'b0;
      bdata  = $urandom;
      exp_ir = word;
      exp_id = eid;
      chk("ir_capture", o_instruction_word, exp_ir);
      chk("id_decode", 32'(o_instruction), 32'(exp_id));
      chk("timeout_state", 32'(o_bus_timeout), 32'(exp_to));
      chk("pc_held", o_pc, exp_pc);
    end
  endtask

  // Called at a negedge in HOLD; go=1 lets fetch restart immediately after.
  task automatic retire(input logic tk, input logic [31:0] tgt, input bit go);
    logic exp_mis;
    load_pc = 1'b1;
    taken   = tk;
    target  = tgt;
    @(negedge clk);
    load_pc = 1'b0;
    taken   = 1'($urandom);
    target  = $urandom;
    if (tk) begin
      exp_pc  = {tgt[31:2], 2'b00};
      exp_mis = (tgt[1:0] != 2'b00);
    end else begin
      exp_pc  = exp_pc + 32'd4;
      exp_mis = 1'b0;
    end
    chk("pc_update", o_pc, exp_pc);
    chk("misaligned_pulse", 32'(o_misaligned), 32'(exp_mis));
    chk("no_read_idle", 32'(o_bus_read), 32'd0);
    if (go) i_state = 1'b0;
    @(negedge clk);
    chk("misaligned_clear", 32'(o_misaligned), 32'd0);
    chk("earliest_req", 32'(o_bus_read), 32'(go));
    chk("pc_stable", o_pc, exp_pc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit          seen;
    logic [31:0] w;
    int          pick;

    pats.push_back('{32'h0000_007F, 32'h0000_0037, 6'd0});
    pats.push_back('{32'h0000_007F, 32'h0000_0017, 6'd1});
    pats.push_back('{32'h0000_007F, 32'h0000_006F, 6'd2});
    pats.push_back('{32'h0000_707F, 32'h0000_0067, 6'd3});
    pats.push_back('{32'h0000_707F, 32'h0000_0063, 6'd4});
    pats.push_back('{32'h0000_707F, 32'h0000_1063, 6'd5});
    pats.push_back('{32'h0000_707F, 32'h0000_4063, 6'd6});
    pats.push_back('{32'h0000_707F, 32'h0000_5063, 6'd7});
    pats.push_back('{32'h0000_707F, 32'h0000_6063, 6'd8});
    pats.push_back('{32'h0000_707F, 32'h0000_7063, 6'd9});
    pats.push_back('{32'h0000_707F, 32'h0000_0013, 6'd10});
    pats.push_back('{32'h0000_707F, 32'h0000_2013, 6'd11});
    pats.push_back('{32'h0000_707F, 32'h0000_3013, 6'd12});
    pats.push_back('{32'h0000_707F, 32'h0000_4013, 6'd13});
    pats.push_back('{32'h0000_707F, 32'h0000_6013, 6'd14});
    pats.push_back('{32'h0000_707F, 32'h0000_7013, 6'd15});
    pats.push_back('{32'hFE00_707F, 32'h0000_1013, 6'd16});
    pats.push_back('{32'hFE00_707F, 32'h0000_5013, 6'd17});
    pats.push_back('{32'hFE00_707F, 32'h4000_5013, 6'd18});
    pats.push_back('{32'hFE00_707F, 32'h0000_0033, 6'd19});
    pats.push_back('{32'hFE00_707F, 32'h4000_0033, 6'd20});
    pats.push_back('{32'hFE00_707F, 32'h0000_1033, 6'd21});
    pats.push_back('{32'hFE00_707F, 32'h0000_2033, 6'd22});
    pats.push_back('{32'hFE00_707F, 32'h0000_3033, 6'd23});
    pats.push_back('{32'hFE00_707F, 32'h0000_4033, 6'd24});
    pats.push_back('{32'hFE00_707F, 32'h0000_5033, 6'd25});
    pats.push_back('{32'hFE00_707F, 32'h4000_5033, 6'd26});
    pats.push_back('{32'h0000_707F, 32'h0000_0003, 6'd27});
    pats.push_back('{32'h0000_707F, 32'h0000_1003, 6'd28});
    pats.push_back('{32'h0000_707F, 32'h0000_2003, 6'd29});
    pats.push_back('{32'h0000_707F, 32'h0000_4003, 6'd30});
    pats.push_back('{32'h0000_707F, 32'h0000_5003, 6'd31});
    pats.push_back('{32'h0000_707F, 32'h0000_0023, 6'd32});
    pats.push_back('{32'h0000_707F, 32'h0000_1023, 6'd33});
    pats.push_back('{32'h0000_707F, 32'h0000_2023, 6'd34});
    pats.push_back('{32'h0000_707F, 32'h0000_000F, 6'd35});
    pats.push_back('{32'hFFFF_FFFF, 32'h0000_0073, 6'd36});
    pats.push_back('{32'hFFFF_FFFF, 32'h0010_0073, 6'd37});

    vecs.push_back('{32'h4000_0033, 6'd20, 1, 1'b0, 32'h0000_0000});
    vecs.push_back('{32'h0200_0033, 6'd63, 0, 1'b0, 32'h0000_0000});
    vecs.push_back('{32'h0000_0073, 6'd36, 2, 1'b1, 32'h0000_2001});
    vecs.push_back('{32'h1234_50B7, 6'd0,  3, 1'b0, 32'h0000_0000});
    vecs.push_back('{32'h0000_006F, 6'd2,  0, 1'b1, 32'h8000_0003});
    vecs.push_back('{32'h0000_7063, 6'd9,  1, 1'b0, 32'h0000_0000});
    vecs.push_back('{32'h4000_5013, 6'd18, 0, 1'b1, 32'h0000_0040});
    vecs.push_back('{32'h2000_5013, 6'd63, 2, 1'b0, 32'h0000_0000});
    vecs.push_back('{32'h0000_0023, 6'd32, 0, 1'b0, 32'h0000_0000});
    vecs.push_back('{32'h0000_6033, 6'd63, 1, 1'b1, 32'h1234_5672});
    vecs.push_back('{32'h0000_000F, 6'd35, 0, 1'b0, 32'h0000_0000});
    vecs.push_back('{32'h0000_5003, 6'd31, 3, 1'b0, 32'h0000_0000});
    vecs.push_back('{32'h0000_1067, 6'd63, 0, 1'b0, 32'h0000_0000});
    vecs.push_back('{32'h0000_2013, 6'd11, 1, 1'b0, 32'h0000_0000});

    rst_n   = 1'b0;
    i_state = 1'b1;
    load_pc = 1'b0;
    taken   = 1'b0;
    target  = 32'h0;
    dv      = 1'b0;
    bdata   = 32'h0;
    exp_pc  = 32'h0;
    exp_to  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", o_pc, 32'h0000_0000);
    chk("rst_ir", o_instruction_word, 32'h0000_0013);
    chk("rst_id", 32'(o_instruction), 32'd10);
    chk("rst_read", 32'(o_bus_read), 32'd0);
    chk("rst_misaligned", 32'(o_misaligned), 32'd0);
    chk("rst_timeout", 32'(o_bus_timeout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // First fetch from the reset vector, NOP returned after a short delay.
    i_state = 1'b0;
    fetch(32'h0000_0013, 6'd10, 2);

    retire(1'b0, 32'h0, 1'b1);
    fetch(32'h0000_2083, 6'd29, 0);

    // Load/store data returning during EXECUTE must not touch IR.
    dv    = 1'b1;
    bdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dv = 1'b0;
    chk("hold_ignores_dv_ir", o_instruction_word, 32'h0000_2083);
    chk("hold_ignores_dv_id", 32'(o_instruction), 32'd29);

    retire(1'b1, 32'h0000_0102, 1'b0);

    // Retire pulse and data valid while IDLE are both ignored.
    load_pc = 1'b1;
    taken   = 1'b1;
    target  = 32'h0000_0500;
    dv      = 1'b1;
    bdata   = 32'h0000_0033;
    @(negedge clk);
    load_pc = 1'b0;
    dv      = 1'b0;
    chk("idle_ignores_load_pc", o_pc, 32'h0000_0100);
    chk("idle_ignores_dv", o_instruction_word, 32'h0000_2083);
    chk("idle_no_read", 32'(o_bus_read), 32'd0);

    // Data valid on the last counted WAIT cycle beats the timeout.
    i_state = 1'b0;
    fetch(32'h0000_0037, 6'd0, TO - 1);

    // Full timeout, reissue at the same PC, then normal capture.
    retire(1'b1, 32'hFFFF_FFFC, 1'b1);
    fetch(32'h0010_0073, 6'd37, TO + 1);

    // Decode table; the first retire wraps the PC from FFFF_FFFC to 0.
    foreach (vecs[i]) begin
      retire(vecs[i].tk, vecs[i].tgt, 1'(i % 2));
      i_state = 1'b0;
      fetch(vecs[i].word, vecs[i].id, vecs[i].delay);
    end

    // Reset asserted mid-WAIT; stale data valid after release is ignored.
    retire(1'b0, 32'h0, 1'b1);
    wait_read(seen);
    @(negedge clk);
    rst_n   = 1'b0;
    i_state = 1'b1;
    #1;
    exp_pc = 32'h0;
    exp_to = 1'b0;
    chk("async_rst_pc", o_pc, exp_pc);
    chk("async_rst_read", 32'(o_bus_read), 32'd0);
    chk("async_rst_timeout", 32'(o_bus_timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dv    = 1'b1;
    bdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dv = 1'b0;
    chk("late_dv_ir", o_instruction_word, 32'h0000_0013);
    chk("late_dv_id", 32'(o_instruction), 32'd10);
    chk("late_dv_pc", o_pc, 32'h0000_0000);
    chk("late_dv_read", 32'(o_bus_read), 32'd0);
    chk("late_dv_misaligned", 32'(o_misaligned), 32'd0);

    i_state = 1'b0;
    fetch(32'h0000_0013, 6'd10, 0);

    // Randomized traffic against the reference decode and PC model.
    for (int it = 0; it < 40; it++) begin
      retire(1'($urandom), $urandom, 1'($urandom));
      pick = $urandom_range(0, 47);
      if (pick < pats.size()) w = pats[pick].match | ($urandom & ~pats[pick].mask);
      else                    w = $urandom;
      i_state = 1'b0;
      fetch(w, ref_decode(w), $urandom_range(0, 5));
      repeat ($urandom_range(0, 2)) begin
        dv    = 1'($urandom);
        bdata = $urandom;
        @(negedge clk);
        dv = 1'b0;
        chk("rand_hold_ir", o_instruction_word, exp_ir);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
